// File: rtl/restoring_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, results held with a done pulse.
// Define DIV_SIGNED_EN for two's-complement operands (adds one FIX cycle to negate results).
module restoring_divider #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Quotient,
  output logic [N-1:0] Remainder,
  output logic         div_zero
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [N-1:0]  r_q, q_q, b_q, a_q;
  logic          dz_q, busy_q, done_q, div_zero_q;
  logic [N-1:0]  quotient_q, remainder_q;

  logic [N:0]    r_shift;
  logic [N-1:0]  r_d, q_d, a_mag, b_mag;
`ifdef DIV_SIGNED_EN
  logic          neg_q_q, neg_r_q;
`endif

  // One trial subtraction. The kept remainder is always below B, so N bits hold it;
  // only the shifted trial value needs the extra bit.
  always_comb begin
    r_shift = {r_q, q_q[N-1]};
    // NOTE: both branches assign r_d and q_d, so this block cannot infer a latch.
    if (r_shift >= {1'b0, b_q}) begin
      r_d = r_shift[N-1:0] - b_q;
      q_d = {q_q[N-2:0], 1'b1};
    end else begin
      r_d = r_shift[N-1:0];
      q_d = {q_q[N-2:0], 1'b0};
    end
  end

`ifdef DIV_SIGNED_EN
  assign a_mag = A[N-1] ? -A : A;
  assign b_mag = B[N-1] ? -B : B;
`else
  assign a_mag = A;
  assign b_mag = B;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      r_q         <= '0;
      q_q         <= '0;
      b_q         <= '0;
      a_q         <= '0;
      dz_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      div_zero_q  <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
`ifdef DIV_SIGNED_EN
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
`endif
    end else begin
      // NOTE: state registers use non-blocking assignments so every read sees pre-edge values.
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            busy_q     <= 1'b1;
            div_zero_q <= 1'b0;
            a_q        <= A;
            b_q        <= b_mag;
            q_q        <= a_mag;
            r_q        <= '0;
            cnt_q      <= CW'(N);
            dz_q       <= (B == '0);
`ifdef DIV_SIGNED_EN
            neg_q_q    <= A[N-1] ^ B[N-1];
            neg_r_q    <= A[N-1];
`endif
            state_q    <= CALC;
          end
        end
        CALC: begin
          if (dz_q) begin
            // Divide-by-zero spends a single cycle and returns fixed results.
            quotient_q  <= '1;
            remainder_q <= a_q;
            div_zero_q  <= 1'b1;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end else begin
            r_q   <= r_d;
            q_q   <= q_d;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
`ifdef DIV_SIGNED_EN
              state_q     <= FIX;
`else
              quotient_q  <= q_d;
              remainder_q <= r_d;
              done_q      <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= IDLE;
`endif
            end
          end
        end
`ifdef DIV_SIGNED_EN
        FIX: begin
          // Quotient truncates toward zero; remainder follows the dividend's sign.
          quotient_q  <= neg_q_q ? -q_q : q_q;
          remainder_q <= neg_r_q ? -r_q : r_q;
          done_q      <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign Quotient  = quotient_q;
  assign Remainder = remainder_q;
  assign div_zero  = div_zero_q;

endmodule
